// File: rtl/check_data_trace_if.sv
// Debug-observation bus between the host debug unit and check_data_trace:
// packed check channels, view/snapshot controls, trace controls and readout.
interface check_data_trace_if #(
  parameter int N_CH   = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int SEL_W  = $clog2(N_CH),
  parameter int PTR_W  = $clog2(DEPTH)
);
  logic [N_CH*DATA_W-1:0] check_data_in;
  logic [SEL_W-1:0]       check_addr;
  logic                   view_snap;
  logic                   snap_req;
  logic                   cpu_en;
  logic [SEL_W-1:0]       trace_ch;
  logic                   trig_en;
  logic [DATA_W-1:0]      trig_val;
  logic                   arm;
  logic                   stop;
  logic [PTR_W-1:0]       rd_idx;
  logic [DATA_W-1:0]      check_data;
  logic [DATA_W-1:0]      trace_data;
  logic [PTR_W:0]         trace_count;
  logic [1:0]             trace_state;

  modport master (
    output check_data_in, check_addr, view_snap, snap_req, cpu_en, trace_ch,
           trig_en, trig_val, arm, stop, rd_idx,
    input  check_data, trace_data, trace_count, trace_state
  );

  modport slave (
    input  check_data_in, check_addr, view_snap, snap_req, cpu_en, trace_ch,
           trig_en, trig_val, arm, stop, rd_idx,
    output check_data, trace_data, trace_count, trace_state
  );
endinterface

// File: rtl/check_data_trace.sv
// Selects one CPU check channel (live or frozen snapshot) onto check_data and
// records one chosen channel into a DEPTH-entry ring buffer under arm/stop/trigger.
module check_data_trace #(
  parameter int N_CH   = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int SEL_W  = $clog2(N_CH),
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  check_data_trace_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [N_CH*DATA_W-1:0] snap_q;
  logic [DATA_W-1:0]      trace_mem [DEPTH];
  state_t                 state_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W:0]         count_q;
  logic [DATA_W-1:0]      check_q;
  logic [DATA_W-1:0]      trace_q;

  logic [DATA_W-1:0]      live_sel;
  logic [DATA_W-1:0]      snap_sel;
  logic [DATA_W-1:0]      sample;
  logic                   wr_en;
  logic                   trig_hit;
  logic [PTR_W-1:0]       oldest;
  logic [PTR_W-1:0]       rd_addr;
  logic                   rd_valid;

  // Out-of-range selects fall through to the zero defaults.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    live_sel = '0;
    snap_sel = '0;
    sample   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.check_addr == SEL_W'(k)) begin
        live_sel = bus.check_data_in[k*DATA_W +: DATA_W];
        snap_sel = snap_q[k*DATA_W +: DATA_W];
      end
      if (bus.trace_ch == SEL_W'(k)) begin
        sample = bus.check_data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  // arm clears the buffer, so it also suppresses a write in the same cycle.
  assign wr_en    = (state_q == ST_RUN) && bus.cpu_en && !bus.arm;
  assign trig_hit = bus.trig_en && bus.cpu_en && (sample == bus.trig_val);

  // Until the ring has wrapped the oldest entry sits at slot 0.
  assign oldest   = (count_q == FULL) ? wr_ptr_q : '0;
  assign rd_addr  = oldest + bus.rd_idx;
  assign rd_valid = {1'b0, bus.rd_idx} < count_q;

  // NOTE: sequential state uses non-blocking <= so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap_q  <= '0;
      check_q <= '0;
    end else begin
      check_q <= bus.view_snap ? snap_sel : live_sel;
      if (bus.snap_req) snap_q <= bus.check_data_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.arm) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (state_q == ST_RUN) begin
      if (bus.cpu_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (count_q != FULL) count_q <= count_q + (PTR_W+1)'(1);
      end
      if (bus.stop || trig_hit) state_q <= ST_DONE;
    end
  end

  // NOTE: the trace RAM has no reset; entries beyond trace_count are never read out.
  always_ff @(posedge clk) begin
    if (wr_en) trace_mem[wr_ptr_q] <= sample;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trace_q <= '0;
    end else begin
      trace_q <= rd_valid ? trace_mem[rd_addr] : '0;
    end
  end

  assign bus.check_data  = check_q;
  assign bus.trace_data  = trace_q;
  assign bus.trace_count = count_q;
  assign bus.trace_state = state_q;

endmodule

// File: tb/tb_check_data_trace.sv
// Directed bench for check_data_trace: a queue-based history model checked every
// cycle, plus hand-computed literal expectations from the test plan.
module tb_check_data_trace;
  localparam int N_CH   = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int SEL_W  = $clog2(N_CH);
  localparam int PTR_W  = $clog2(DEPTH);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  check_data_trace_if #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH),
                        .SEL_W(SEL_W), .PTR_W(PTR_W)) bus ();

  check_data_trace #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH),
                     .SEL_W(SEL_W), .PTR_W(PTR_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: snapshot array, history queue (oldest first) and a state number.
  logic [DATA_W-1:0] m_snap [N_CH];
  logic [DATA_W-1:0] m_hist [$];
  int                m_state;
  logic [DATA_W-1:0] e_check;
  logic [DATA_W-1:0] e_trace;
  logic [DATA_W-1:0] m_s;
  int                m_a;
  int                m_i;

  function automatic logic [DATA_W-1:0] live_ch(input int k);
    if (k < N_CH) return bus.check_data_in[k*DATA_W +: DATA_W];
    return '0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N_CH; k++) m_snap[k] = '0;
      m_hist.delete();
      m_state = 0;
      e_check = '0;
      e_trace = '0;
    end else begin
      m_a = int'(bus.check_addr);
      if (m_a < N_CH) e_check = bus.view_snap ? m_snap[m_a] : live_ch(m_a);
      else            e_check = '0;
      m_i = int'(bus.rd_idx);
      e_trace = (m_i < m_hist.size()) ? m_hist[m_i] : '0;
      if (bus.snap_req)
        for (int k = 0; k < N_CH; k++) m_snap[k] = live_ch(k);
      m_s = live_ch(int'(bus.trace_ch));
      if (bus.arm) begin
        m_hist.delete();
        m_state = 1;
      end else if (m_state == 1) begin
        if (bus.cpu_en) begin
          if (m_hist.size() == DEPTH) void'(m_hist.pop_front());
          m_hist.push_back(m_s);
        end
        if (bus.stop || (bus.trig_en && bus.cpu_en && m_s == bus.trig_val)) m_state = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_check_data",  bus.check_data, e_check);
      check("cyc_trace_data",  bus.trace_data, e_trace);
      check("cyc_trace_count", 32'(bus.trace_count), 32'(m_hist.size()));
      check("cyc_trace_state", 32'(bus.trace_state), 32'(m_state));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
    bus.check_data_in[k*DATA_W +: DATA_W] = v;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  initial begin
    bus.check_data_in = '0;
    bus.check_addr    = '0;
    bus.view_snap     = 1'b0;
    bus.snap_req      = 1'b0;
    bus.cpu_en        = 1'b0;
    bus.trace_ch      = '0;
    bus.trig_en       = 1'b0;
    bus.trig_val      = '0;
    bus.arm           = 1'b0;
    bus.stop          = 1'b0;
    bus.rd_idx        = '0;

    repeat (2) tick();
    check("rst_check_data",  bus.check_data, 32'h0);
    check("rst_trace_data",  bus.trace_data, 32'h0);
    check("rst_trace_count", 32'(bus.trace_count), 32'd0);
    check("rst_trace_state", 32'(bus.trace_state), 32'd0);
    rstn   = 1'b1;
    cmp_en = 1'b1;

    // Live select sweep, including the two unused addresses.
    for (int k = 0; k < N_CH; k++) set_ch(k, 32'h1000_0000 + 32'(k));
    for (int a = 0; a < 8; a++) begin
      bus.check_addr = SEL_W'(a);
      tick();
      check("live_sel", bus.check_data, (a < N_CH) ? 32'h1000_0000 + 32'(a) : 32'h0);
    end

    // Snapshot capture, then live change, then view both copies.
    set_ch(2, 32'hAAAA_0002);
    bus.snap_req = 1'b1;
    tick();
    bus.snap_req = 1'b0;
    set_ch(2, 32'h5555_0002);
    bus.check_addr = SEL_W'(2);
    bus.view_snap  = 1'b1;
    tick();
    check("snap_view", bus.check_data, 32'hAAAA_0002);
    bus.view_snap = 1'b0;
    tick();
    check("snap_live", bus.check_data, 32'h5555_0002);
    bus.view_snap = 1'b1;
    bus.snap_req  = 1'b1;
    tick();
    check("snap_same_cycle_old", bus.check_data, 32'hAAAA_0002);
    bus.snap_req = 1'b0;
    tick();
    check("snap_same_cycle_new", bus.check_data, 32'h5555_0002);
    bus.view_snap = 1'b0;

    // Wrap: 20 samples into a 16-deep ring.
    bus.trace_ch = SEL_W'(3);
    pulse_arm();
    check("arm_state", 32'(bus.trace_state), 32'd1);
    bus.cpu_en = 1'b1;
    for (int v = 1; v <= 20; v++) begin
      set_ch(3, 32'(v));
      tick();
    end
    bus.cpu_en = 1'b0;
    bus.stop   = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("wrap_count", 32'(bus.trace_count), 32'd16);
    check("wrap_state", 32'(bus.trace_state), 32'd2);
    bus.rd_idx = PTR_W'(0);
    tick();
    check("wrap_rd0", bus.trace_data, 32'd5);
    bus.rd_idx = PTR_W'(15);
    tick();
    check("wrap_rd15", bus.trace_data, 32'd20);

    // cpu_en gating and value trigger.
    pulse_arm();
    bus.trig_en  = 1'b1;
    bus.trig_val = 32'h30;
    bus.cpu_en = 1'b1; set_ch(3, 32'h10); tick();
    bus.cpu_en = 1'b0; set_ch(3, 32'h20); tick();
    bus.cpu_en = 1'b1; set_ch(3, 32'h30); tick();
    bus.cpu_en = 1'b1; set_ch(3, 32'h40); tick();
    bus.cpu_en  = 1'b0;
    bus.trig_en = 1'b0;
    check("trig_state", 32'(bus.trace_state), 32'd2);
    check("trig_count", 32'(bus.trace_count), 32'd2);
    bus.rd_idx = PTR_W'(0);
    tick();
    check("trig_rd0", bus.trace_data, 32'h10);
    bus.rd_idx = PTR_W'(1);
    tick();
    check("trig_rd1", bus.trace_data, 32'h30);
    bus.rd_idx = PTR_W'(2);
    tick();
    check("trig_rd_past_count", bus.trace_data, 32'h0);

    // arm beats stop while DONE.
    bus.arm  = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.arm  = 1'b0;
    bus.stop = 1'b0;
    check("prio_state", 32'(bus.trace_state), 32'd1);
    check("prio_count", 32'(bus.trace_count), 32'd0);
    bus.rd_idx = PTR_W'(0);
    tick();
    check("prio_rd0", bus.trace_data, 32'h0);

    // Out-of-range trace channel records zero; stop with cpu_en writes a sample.
    bus.trace_ch = SEL_W'(7);
    bus.cpu_en   = 1'b1;
    tick();
    bus.trace_ch = SEL_W'(3);
    set_ch(3, 32'h77);
    bus.stop = 1'b1;
    tick();
    bus.stop   = 1'b0;
    bus.cpu_en = 1'b0;
    check("stopwr_count", 32'(bus.trace_count), 32'd2);
    check("stopwr_state", 32'(bus.trace_state), 32'd2);
    bus.rd_idx = PTR_W'(0);
    tick();
    check("oor_ch_rd0", bus.trace_data, 32'h0);
    bus.rd_idx = PTR_W'(1);
    tick();
    check("stopwr_rd1", bus.trace_data, 32'h77);

    // Asynchronous reset in the middle of a capture.
    pulse_arm();
    bus.cpu_en = 1'b1;
    for (int v = 0; v < 5; v++) begin
      set_ch(3, 32'h100 + 32'(v));
      tick();
    end
    bus.cpu_en = 1'b0;
    check("pre_rst_count", 32'(bus.trace_count), 32'd5);
    #2;
    cmp_en = 1'b0;
    rstn   = 1'b0;
    #1;
    check("arst_check_data",  bus.check_data, 32'h0);
    check("arst_trace_data",  bus.trace_data, 32'h0);
    check("arst_trace_count", 32'(bus.trace_count), 32'd0);
    check("arst_trace_state", 32'(bus.trace_state), 32'd0);
    tick();
    tick();
    rstn   = 1'b1;
    cmp_en = 1'b1;
    tick();
    check("post_rst_state", 32'(bus.trace_state), 32'd0);
    pulse_arm();
    set_ch(3, 32'hABC);
    bus.cpu_en = 1'b1;
    tick();
    bus.cpu_en = 1'b0;
    check("resume_count", 32'(bus.trace_count), 32'd1);
    bus.rd_idx = PTR_W'(0);
    tick();
    check("resume_rd0", bus.trace_data, 32'hABC);

    tick();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
